// File: rtl/riscv_axi_pkg.sv
// Shared types and constants for the core-to-AXI4-Lite memory bridge.
package riscv_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        OWN_DW = 2'd0,
        OWN_DR = 2'd1,
        OWN_IR = 2'd2
    } owner_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DATA  = 3'b000;
    localparam logic [2:0] PROT_INSTR = 3'b100;

    function automatic logic resp_is_err(input logic [1:0] resp);
        logic err;
        case (resp)
            AXI_RESP_OKAY, AXI_RESP_EXOKAY:   err = 1'b0;
            AXI_RESP_SLVERR, AXI_RESP_DECERR: err = 1'b1;
            default:                          err = 1'b0;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/riscv_axi_bridge_arb.sv
// Fixed-priority grant between the three cache requesters:
// dcache write > dcache read > icache read.
module riscv_axi_bridge_arb
    import riscv_axi_pkg::*;
(
    input  logic   dw_valid_i,
    input  logic   dr_valid_i,
    input  logic   ir_valid_i,
    output logic   grant_o,
    output owner_e owner_o
);

    always_comb begin
        grant_o = dw_valid_i | dr_valid_i | ir_valid_i;
        owner_o = OWN_DW;
        if (dw_valid_i)      owner_o = OWN_DW;
        else if (dr_valid_i) owner_o = OWN_DR;
        else if (ir_valid_i) owner_o = OWN_IR;
    end

endmodule

// File: rtl/riscv_axi_bridge.sv
// Bridges the level-request / pulse-done cache ports onto one AXI4-Lite master,
// one transaction at a time.
module riscv_axi_bridge
    import riscv_axi_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                  i_riscv_axi_bridge_clk,
    input  logic                  i_riscv_axi_bridge_rst_n,
    input  logic [ADDR_W-1:0]     i_dcache_raddr,
    input  logic                  i_dcache_raddr_valid,
    output logic                  o_dcache_rready,
    output logic [DATA_W-1:0]     o_dcache_rdata,
    input  logic [ADDR_W-1:0]     i_dcache_waddr,
    input  logic [DATA_W-1:0]     i_dcache_wdata,
    input  logic [DATA_W/8-1:0]   i_dcache_wstrb,
    input  logic                  i_dcache_wvalid,
    output logic                  o_dcache_wresp,
    input  logic [ADDR_W-1:0]     i_icache_raddr,
    input  logic                  i_icache_raddr_valid,
    output logic                  o_icache_rready,
    output logic [DATA_W-1:0]     o_icache_rdata,
    output logic                  o_bus_err,
    output logic [ADDR_W-1:0]     o_awaddr,
    output logic [2:0]            o_awprot,
    output logic                  o_awvalid,
    input  logic                  i_awready,
    output logic [DATA_W-1:0]     o_wdata,
    output logic [DATA_W/8-1:0]   o_wstrb,
    output logic                  o_wvalid,
    input  logic                  i_wready,
    input  logic [1:0]            i_bresp,
    input  logic                  i_bvalid,
    output logic                  o_bready,
    output logic [ADDR_W-1:0]     o_araddr,
    output logic [2:0]            o_arprot,
    output logic                  o_arvalid,
    input  logic                  i_arready,
    input  logic [DATA_W-1:0]     i_rdata,
    input  logic [1:0]            i_rresp,
    input  logic                  i_rvalid,
    output logic                  o_rready
);

    state_e                state_q;
    owner_e                owner_q;
    owner_e                grant_owner;
    logic                  grant;
    logic                  aw_done_q, w_done_q;
    logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [ADDR_W-1:0]     awaddr_q, araddr_q;
    logic [DATA_W-1:0]     wdata_q, rdata_q;
    logic [DATA_W/8-1:0]   wstrb_q;
    logic [2:0]            arprot_q;
    logic                  dw_done_q, dr_done_q, ir_done_q, bus_err_q;
    logic                  aw_hs, w_hs;

    riscv_axi_bridge_arb u_arb (
        .dw_valid_i (i_dcache_wvalid),
        .dr_valid_i (i_dcache_raddr_valid),
        .ir_valid_i (i_icache_raddr_valid),
        .grant_o    (grant),
        .owner_o    (grant_owner)
    );

    assign aw_hs = awvalid_q & i_awready;
    assign w_hs  = wvalid_q & i_wready;

    always_ff @(posedge i_riscv_axi_bridge_clk) begin
        if (!i_riscv_axi_bridge_rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_DW;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            arprot_q  <= PROT_DATA;
            rdata_q   <= '0;
            dw_done_q <= 1'b0;
            dr_done_q <= 1'b0;
            ir_done_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant) begin
                        owner_q <= grant_owner;
                        case (grant_owner)
                            OWN_DW: begin
                                awaddr_q  <= i_dcache_waddr;
                                wdata_q   <= i_dcache_wdata;
                                wstrb_q   <= i_dcache_wstrb;
                                awvalid_q <= 1'b1;
                                wvalid_q  <= 1'b1;
                                aw_done_q <= 1'b0;
                                w_done_q  <= 1'b0;
                                state_q   <= ST_WR_REQ;
                            end
                            OWN_DR: begin
                                araddr_q  <= i_dcache_raddr;
                                arprot_q  <= PROT_DATA;
                                arvalid_q <= 1'b1;
                                state_q   <= ST_RD_ADDR;
                            end
                            default: begin
                                araddr_q  <= i_icache_raddr;
                                arprot_q  <= PROT_INSTR;
                                arvalid_q <= 1'b1;
                                state_q   <= ST_RD_ADDR;
                            end
                        endcase
                    end
                end
                // AW and W complete independently; leave once both have.
                ST_WR_REQ: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (i_bvalid) begin
                        bready_q  <= 1'b0;
                        bus_err_q <= resp_is_err(i_bresp);
                        dw_done_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                ST_RD_ADDR: begin
                    if (i_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (i_rvalid) begin
                        rready_q  <= 1'b0;
                        rdata_q   <= i_rdata;
                        bus_err_q <= resp_is_err(i_rresp);
                        if (owner_q == OWN_IR) ir_done_q <= 1'b1;
                        else                   dr_done_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    dw_done_q <= 1'b0;
                    dr_done_q <= 1'b0;
                    ir_done_q <= 1'b0;
                    bus_err_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_awaddr        = awaddr_q;
    assign o_awprot        = PROT_DATA;
    assign o_awvalid       = awvalid_q;
    assign o_wdata         = wdata_q;
    assign o_wstrb         = wstrb_q;
    assign o_wvalid        = wvalid_q;
    assign o_bready        = bready_q;
    assign o_araddr        = araddr_q;
    assign o_arprot        = arprot_q;
    assign o_arvalid       = arvalid_q;
    assign o_rready        = rready_q;
    assign o_dcache_rready = dr_done_q;
    assign o_dcache_rdata  = rdata_q;
    assign o_icache_rready = ir_done_q;
    assign o_icache_rdata  = rdata_q;
    assign o_dcache_wresp  = dw_done_q;
    assign o_bus_err       = bus_err_q;

endmodule

// File: tb/tb_riscv_axi_bridge.sv
// Scoreboard bench: requests push expected AXI address phases and done events,
// a behavioural AXI4-Lite slave and a done monitor pop and compare them.
module tb_riscv_axi_bridge;
    import riscv_axi_pkg::*;

    localparam int K_DW = 0;
    localparam int K_DR = 1;
    localparam int K_IR = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] i_dcache_raddr = '0, i_dcache_waddr = '0, i_dcache_wdata = '0, i_icache_raddr = '0;
    logic [7:0]  i_dcache_wstrb = '0;
    logic        i_dcache_raddr_valid = 1'b0, i_dcache_wvalid = 1'b0, i_icache_raddr_valid = 1'b0;
    logic        o_dcache_rready, o_dcache_wresp, o_icache_rready, o_bus_err;
    logic [63:0] o_dcache_rdata, o_icache_rdata;
    logic [63:0] o_awaddr, o_wdata, o_araddr;
    logic [2:0]  o_awprot, o_arprot;
    logic [7:0]  o_wstrb;
    logic        o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready;
    logic        i_awready = 1'b0, i_wready = 1'b0, i_bvalid = 1'b0, i_arready = 1'b0, i_rvalid = 1'b0;
    logic [1:0]  i_bresp = '0, i_rresp = '0;
    logic [63:0] i_rdata = '0;

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [2:0]  prot;
        logic [63:0] wdata;
        logic [7:0]  strb;
    } addr_t;

    typedef struct {
        logic [1:0]  kind;
        logic [63:0] data;
        logic        err;
    } done_t;

    addr_t       aq[$];
    done_t       dq[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          ar_wait = 0, aw_wait = 0, w_wait = 0, r_wait = 0;
    logic [63:0] r_data = '0;
    logic [1:0]  r_resp = 2'b00, b_resp = 2'b00;

    riscv_axi_bridge #(.ADDR_W(64), .DATA_W(64)) dut (
        .i_riscv_axi_bridge_clk   (clk),
        .i_riscv_axi_bridge_rst_n (rst_n),
        .i_dcache_raddr           (i_dcache_raddr),
        .i_dcache_raddr_valid     (i_dcache_raddr_valid),
        .o_dcache_rready          (o_dcache_rready),
        .o_dcache_rdata           (o_dcache_rdata),
        .i_dcache_waddr           (i_dcache_waddr),
        .i_dcache_wdata           (i_dcache_wdata),
        .i_dcache_wstrb           (i_dcache_wstrb),
        .i_dcache_wvalid          (i_dcache_wvalid),
        .o_dcache_wresp           (o_dcache_wresp),
        .i_icache_raddr           (i_icache_raddr),
        .i_icache_raddr_valid     (i_icache_raddr_valid),
        .o_icache_rready          (o_icache_rready),
        .o_icache_rdata           (o_icache_rdata),
        .o_bus_err                (o_bus_err),
        .o_awaddr                 (o_awaddr),
        .o_awprot                 (o_awprot),
        .o_awvalid                (o_awvalid),
        .i_awready                (i_awready),
        .o_wdata                  (o_wdata),
        .o_wstrb                  (o_wstrb),
        .o_wvalid                 (o_wvalid),
        .i_wready                 (i_wready),
        .i_bresp                  (i_bresp),
        .i_bvalid                 (i_bvalid),
        .o_bready                 (o_bready),
        .o_araddr                 (o_araddr),
        .o_arprot                 (o_arprot),
        .o_arvalid                (o_arvalid),
        .i_arready                (i_arready),
        .i_rdata                  (i_rdata),
        .i_rresp                  (i_rresp),
        .i_rvalid                 (i_rvalid),
        .o_rready                 (o_rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Read-channel slave: ar_wait cycles before arready, r_wait cycles before rvalid.
    initial begin
        addr_t       e;
        logic [63:0] a0;
        bit          abort;
        int          k;
        forever begin
            @(negedge clk);
            if (rst_n && o_arvalid) begin
                if (aq.size() == 0) check("ar_unexpected", {63'd0, o_arvalid}, 64'd0);
                else begin
                    e = aq.pop_front();
                    check("ar_is_read", {63'd0, e.wr}, 64'd0);
                    check("araddr", o_araddr, e.addr);
                    check("arprot", {61'd0, o_arprot}, {61'd0, e.prot});
                end
                a0 = o_araddr;
                for (int i = 0; i < ar_wait; i++) begin
                    @(negedge clk);
                    check("arvalid_hold", {63'd0, o_arvalid}, 64'd1);
                    check("araddr_hold", o_araddr, a0);
                end
                i_arready = 1'b1;
                @(negedge clk);
                i_arready = 1'b0;
                check("arvalid_drop", {63'd0, o_arvalid}, 64'd0);
                abort = 1'b0;
                k = 0;
                while (k < r_wait && !abort) begin
                    @(negedge clk);
                    if (!rst_n) abort = 1'b1;
                    k++;
                end
                if (!abort && rst_n) begin
                    check("rready_wait", {63'd0, o_rready}, 64'd1);
                    i_rvalid = 1'b1;
                    i_rdata  = r_data;
                    i_rresp  = r_resp;
                    @(negedge clk);
                    i_rvalid = 1'b0;
                    i_rdata  = '0;
                    i_rresp  = 2'b00;
                end
            end
        end
    end

    // Write-channel slave: independent aw/w delays, then a zero-wait B response.
    initial begin
        addr_t e;
        int    acnt, wcnt, guard;
        bit    aok, wok;
        forever begin
            @(negedge clk);
            if (rst_n && (o_awvalid || o_wvalid)) begin
                check("aw_w_together", {63'd0, o_awvalid & o_wvalid}, 64'd1);
                if (aq.size() == 0) check("aw_unexpected", {63'd0, o_awvalid}, 64'd0);
                else begin
                    e = aq.pop_front();
                    check("aw_is_write", {63'd0, e.wr}, 64'd1);
                    check("awaddr", o_awaddr, e.addr);
                    check("awprot", {61'd0, o_awprot}, 64'd0);
                    check("wdata", o_wdata, e.wdata);
                    check("wstrb", {56'd0, o_wstrb}, {56'd0, e.strb});
                end
                acnt = aw_wait; wcnt = w_wait; aok = 1'b0; wok = 1'b0; guard = 0;
                while (!(aok && wok) && guard < 50) begin
                    i_awready = !aok && (acnt == 0);
                    i_wready  = !wok && (wcnt == 0);
                    @(negedge clk);
                    if (i_awready) aok = 1'b1;
                    if (i_wready)  wok = 1'b1;
                    if (acnt > 0) acnt--;
                    if (wcnt > 0) wcnt--;
                    check("awvalid_state", {63'd0, o_awvalid}, {63'd0, !aok});
                    check("wvalid_state", {63'd0, o_wvalid}, {63'd0, !wok});
                    guard++;
                end
                i_awready = 1'b0;
                i_wready  = 1'b0;
                check("bready_wait", {63'd0, o_bready}, 64'd1);
                i_bvalid = 1'b1;
                i_bresp  = b_resp;
                @(negedge clk);
                i_bvalid = 1'b0;
                i_bresp  = 2'b00;
            end
        end
    end

    // Done monitor: every done pulse must match the head of the scoreboard.
    initial begin
        done_t      e;
        logic [1:0] kind;
        forever begin
            @(negedge clk);
            if (o_arvalid && (o_awvalid || o_wvalid))
                check("axi_overlap", {63'd0, o_arvalid}, 64'd0);
            if (o_dcache_wresp || o_dcache_rready || o_icache_rready) begin
                check("one_done", 64'($countones({o_dcache_wresp, o_dcache_rready, o_icache_rready})), 64'd1);
                kind = o_dcache_wresp ? 2'(K_DW) : (o_dcache_rready ? 2'(K_DR) : 2'(K_IR));
                if (dq.size() == 0)
                    check("unexpected_done", {61'd0, o_dcache_wresp, o_dcache_rready, o_icache_rready}, 64'd0);
                else begin
                    e = dq.pop_front();
                    check("done_kind", {62'd0, kind}, {62'd0, e.kind});
                    if (kind == 2'(K_DR)) check("dcache_rdata", o_dcache_rdata, e.data);
                    if (kind == 2'(K_IR)) check("icache_rdata", o_icache_rdata, e.data);
                    check("bus_err", {63'd0, o_bus_err}, {63'd0, e.err});
                end
            end else if (o_bus_err) begin
                check("stray_bus_err", {63'd0, o_bus_err}, 64'd0);
            end
        end
    end

    task automatic expect_txn(input int kind, input logic [63:0] addr, input logic [63:0] wd,
                              input logic [7:0] strb, input logic [1:0] resp);
        addr_t a;
        done_t d;
        a.wr    = (kind == K_DW);
        a.addr  = addr;
        a.prot  = (kind == K_IR) ? 3'b100 : 3'b000;
        a.wdata = wd;
        a.strb  = strb;
        aq.push_back(a);
        d.kind  = 2'(kind);
        d.data  = (kind == K_DW) ? 64'd0 : r_data;
        d.err   = resp[1];
        dq.push_back(d);
    endtask

    task automatic set_valid(input int kind, input logic v);
        case (kind)
            K_DW:    i_dcache_wvalid = v;
            K_DR:    i_dcache_raddr_valid = v;
            default: i_icache_raddr_valid = v;
        endcase
    endtask

    function automatic logic done_of(input int kind);
        case (kind)
            K_DW:    return o_dcache_wresp;
            K_DR:    return o_dcache_rready;
            default: return o_icache_rready;
        endcase
    endfunction

    // Single request; call right after a negedge. exp_lat counts negedges to the done pulse.
    task automatic run(input int kind, input logic [63:0] addr, input logic [63:0] wd,
                       input logic [7:0] strb, input logic [1:0] resp, input int exp_lat);
        int   n;
        logic seen;
        expect_txn(kind, addr, wd, strb, resp);
        if (kind == K_DW) begin
            b_resp = resp;
            i_dcache_waddr = addr; i_dcache_wdata = wd; i_dcache_wstrb = strb;
        end else begin
            r_resp = resp;
            if (kind == K_DR) i_dcache_raddr = addr;
            else              i_icache_raddr = addr;
        end
        set_valid(kind, 1'b1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            seen = done_of(kind);
        end
        set_valid(kind, 1'b0);
        check("done_seen", {63'd0, seen}, 64'd1);
        if (exp_lat > 0) check("latency", 64'(n), 64'(exp_lat));
        @(negedge clk);
    endtask

    initial begin
        bit   got_dw, got_dr, got_ir;
        int   n;
        // reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {55'd0, o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready,
                           o_dcache_rready, o_dcache_wresp, o_icache_rready, o_bus_err}, 64'd0);
        check("rst_addr", o_awaddr | o_araddr | o_wdata | {56'd0, o_wstrb}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // zero-wait dcache read
        r_data = 64'hDEAD_BEEF_0123_4567;
        run(K_DR, 64'h8000_0040, '0, '0, 2'b00, 3);

        // icache refill with arready held off for 4 cycles
        ar_wait = 4;
        r_data  = 64'h0A0B_0C0D_1020_3040;
        run(K_IR, 64'h1000, '0, '0, 2'b00, 7);
        ar_wait = 0;

        // zero-wait write, then wready two cycles ahead of awready, then the reverse
        run(K_DW, 64'h2008, 64'hCAFE_F00D_5555_AAAA, 8'hFF, 2'b00, 3);
        aw_wait = 2;
        run(K_DW, 64'h2000, 64'h1122_3344_5566_7788, 8'h0F, 2'b00, 5);
        aw_wait = 0; w_wait = 3;
        run(K_DW, 64'h2010, 64'h0102_0304_0506_0708, 8'hF0, 2'b00, 6);
        w_wait = 0;

        // error responses still return data and pulse bus_err
        r_data = 64'h5A5A_0000_FFFF_1234;
        run(K_DR, 64'h4000, '0, '0, 2'b10, 3);
        run(K_IR, 64'h4100, '0, '0, 2'b11, 3);
        run(K_DW, 64'h4200, 64'h77, 8'h01, 2'b10, 3);
        run(K_DR, 64'h4300, '0, '0, 2'b01, 3);

        // three simultaneous requests: write, then dcache read, then icache read
        r_data = 64'h1357_9BDF_2468_ACE0;
        r_resp = 2'b00; b_resp = 2'b00;
        expect_txn(K_DW, 64'h3000, 64'hABCD, 8'h3C, 2'b00);
        expect_txn(K_DR, 64'h3100, '0, '0, 2'b00);
        expect_txn(K_IR, 64'h3200, '0, '0, 2'b00);
        i_dcache_waddr = 64'h3000; i_dcache_wdata = 64'hABCD; i_dcache_wstrb = 8'h3C;
        i_dcache_raddr = 64'h3100; i_icache_raddr = 64'h3200;
        i_dcache_wvalid = 1'b1; i_dcache_raddr_valid = 1'b1; i_icache_raddr_valid = 1'b1;
        got_dw = 1'b0; got_dr = 1'b0; got_ir = 1'b0; n = 0;
        while (!(got_dw && got_dr && got_ir) && n < 300) begin
            @(negedge clk);
            n++;
            if (o_dcache_wresp)  begin got_dw = 1'b1; i_dcache_wvalid = 1'b0; end
            if (o_dcache_rready) begin got_dr = 1'b1; i_dcache_raddr_valid = 1'b0; end
            if (o_icache_rready) begin got_ir = 1'b1; i_icache_raddr_valid = 1'b0; end
        end
        i_dcache_wvalid = 1'b0; i_dcache_raddr_valid = 1'b0; i_icache_raddr_valid = 1'b0;
        check("multi_all_done", {61'd0, got_dw, got_dr, got_ir}, 64'd7);
        check("multi_cycles", 64'(n), 64'd11);
        @(negedge clk);

        // reset while waiting in RD_DATA abandons the read silently
        r_wait = 10;
        begin
            addr_t a;
            a.wr = 1'b0; a.addr = 64'h5000; a.prot = 3'b000; a.wdata = '0; a.strb = '0;
            aq.push_back(a);
        end
        i_dcache_raddr = 64'h5000;
        i_dcache_raddr_valid = 1'b1;
        n = 0;
        while (!o_rready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach_rd_data", {63'd0, o_rready}, 64'd1);
        rst_n = 1'b0;
        i_dcache_raddr_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_state", 64'(dut.state_q), 64'(ST_IDLE));
        check("rst_mid_ctrl", {57'd0, o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready,
                               o_dcache_rready, o_bus_err}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        r_wait = 0;
        repeat (6) @(negedge clk);

        // bridge recovers after the abandoned read
        r_data = 64'h0F0F_F0F0_0000_0001;
        run(K_DR, 64'h6000, '0, '0, 2'b00, 3);

        check("aq_empty", 64'(aq.size()), 64'd0);
        check("dq_empty", 64'(dq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
